ps2_scancode_rx: RTL and testbench

- Keyboard-side front end that produces the key-event stream consumed by the matrix mapper.
- Samples raw PS/2 clock and data pins and deserializes 11-bit device-to-host frames.
- Resolves the set-2 prefixes E0 (extended) and F0 (break).
- Emits one single-cycle strobe per key event: key_strobe, key_pressed, key_extended, key_code.

---
 rtl/ps2_scancode_rx.sv | 217 +++++++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx
//   PS/2 keyboard receiver. Deserializes 11-bit device-to-host frames, strips
//   the set-2 E0 (extended) / F0 (break) prefixes, swallows the Pause (E1)
//   sequence and device responses, and emits one strobe per key event.
//
//   Optional: define KBD_TYPEMATIC_FILTER_EN to suppress typematic repeat
//   makes of the most recently pressed key.
//
// Parameters
//   FILTER_LEN  depth of the ps2_clk glitch filter (clk_sys cycles)
//   TIMEOUT     clk_sys cycles allowed between falls inside a frame
//
// Ports
//   clk_sys       system clock
//   reset_n       asynchronous active-low reset
//   ps2_clk       raw PS/2 clock pin (asynchronous)
//   ps2_data      raw PS/2 data pin (asynchronous)
//   key_strobe    one-cycle pulse per decoded key event
//   key_pressed   1 = make, 0 = break (held between strobes)
//   key_extended  event was prefixed by E0 (held between strobes)
//   key_code      scancode byte, prefixes stripped (held between strobes)
//   frame_err     one-cycle pulse on parity, stop or timeout error
module ps2_scancode_rx #(
   parameter int unsigned FILTER_LEN = 8,
   parameter int unsigned TIMEOUT    = 50000
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       key_strobe,
   output logic       key_pressed,
   output logic       key_extended,
   output logic [7:0] key_code,
   output logic       frame_err
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   state_t state, state_nxt;

   logic [1:0]            clk_sync, dat_sync;
   logic [FILTER_LEN-1:0] filt_sr;
   logic                  clk_filt;
   logic                  fall;
   logic                  data_bit;

   logic [TW-1:0] to_cnt;
   logic          tmo_err, stop_ok, stop_bad;

   logic [7:0] shreg;
   logic [2:0] bit_idx;
   logic       par_bit;

   logic       ext_flag, rel_flag;
   logic [2:0] skip_cnt;
   logic       is_resp, key_event, is_repeat;

   // Synchronizers and glitch filter; idle line level is high.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         clk_sync <= '1;
         dat_sync <= '1;
         filt_sr  <= '1;
         clk_filt <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_data};
         filt_sr  <= {filt_sr[FILTER_LEN-2:0], clk_sync[1]};
         if (&filt_sr)
            clk_filt <= 1'b1;
         else if (filt_sr == '0)
            clk_filt <= 1'b0;
      end
   end

   // Fall is flagged on the cycle the filtered clock is about to drop.
   assign fall     = clk_filt && (filt_sr == '0);
   assign data_bit = dat_sync[1];

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         to_cnt <= '0;
      else if (state == S_IDLE || fall)
         to_cnt <= '0;
      else if (to_cnt != TO_MAX)
         to_cnt <= to_cnt + TW'(1);
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tmo_err   = 1'b0;
      stop_ok   = 1'b0;
      stop_bad  = 1'b0;
      if (state != S_IDLE && to_cnt == TO_MAX) begin
         state_nxt = S_IDLE;
         tmo_err   = 1'b1;
      end else if (fall) begin
         case (state)
            S_IDLE:   if (!data_bit) state_nxt = S_DATA;
            S_DATA:   if (bit_idx == 3'd7) state_nxt = S_PARITY;
            S_PARITY: state_nxt = S_STOP;
            S_STOP: begin
               state_nxt = S_IDLE;
               if (data_bit && (^{shreg, par_bit}))
                  stop_ok = 1'b1;
               else
                  stop_bad = 1'b1;
            end
            default:  state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         shreg   <= '0;
         bit_idx <= '0;
         par_bit <= 1'b0;
      end else if (fall) begin
         case (state)
            S_IDLE: bit_idx <= '0;
            S_DATA: begin
               shreg   <= {data_bit, shreg[7:1]};
               bit_idx <= bit_idx + 3'd1;
            end
            S_PARITY: par_bit <= data_bit;
            default: ;
         endcase
      end
   end

   assign is_resp = shreg inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF};

   // Decoded from the byte still in shreg on the accepting STOP fall, so the
   // registered strobe lands one cycle after that fall.
   assign key_event = stop_ok && (skip_cnt == '0)
                      && !(shreg inside {8'hE0, 8'hF0, 8'hE1})
                      && !(!ext_flag && !rel_flag && is_resp);

`ifdef KBD_TYPEMATIC_FILTER_EN
   logic       rec_valid, rec_ext;
   logic [7:0] rec_code;

   assign is_repeat = !rel_flag && rec_valid && (rec_ext == ext_flag) && (rec_code == shreg);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         rec_valid <= 1'b0;
         rec_ext   <= 1'b0;
         rec_code  <= '0;
      end else if (stop_bad || tmo_err) begin
         rec_valid <= 1'b0;
      end else if (key_event) begin
         if (!rel_flag) begin
            rec_valid <= 1'b1;
            rec_ext   <= ext_flag;
            rec_code  <= shreg;
         end else if (rec_valid && rec_ext == ext_flag && rec_code == shreg) begin
            rec_valid <= 1'b0;
         end
      end
   end
`else
   assign is_repeat = 1'b0;
`endif

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         key_strobe   <= 1'b0;
         key_pressed  <= 1'b0;
         key_extended <= 1'b0;
         key_code     <= '0;
         frame_err    <= 1'b0;
         ext_flag     <= 1'b0;
         rel_flag     <= 1'b0;
         skip_cnt     <= '0;
      end else begin
         key_strobe <= 1'b0;
         frame_err  <= stop_bad || tmo_err;
         if (stop_bad) begin
            ext_flag <= 1'b0;
            rel_flag <= 1'b0;
         end else if (stop_ok) begin
            if (skip_cnt != '0)
               skip_cnt <= skip_cnt - 3'd1;
            else if (shreg == 8'hE0)
               ext_flag <= 1'b1;
            else if (shreg == 8'hF0)
               rel_flag <= 1'b1;
            else if (shreg == 8'hE1)
               skip_cnt <= 3'd7;
            if (key_event) begin
               ext_flag <= 1'b0;
               rel_flag <= 1'b0;
               if (!is_repeat) begin
                  key_strobe   <= 1'b1;
                  key_code     <= shreg;
                  key_pressed  <= ~rel_flag;
                  key_extended <= ext_flag;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
module tb_ps2_scancode_rx;

   localparam int unsigned TO = 1000;

   logic       clk_sys  = 1'b0;
   logic       reset_n  = 1'b0;
   logic       ps2_clk  = 1'b1;
   logic       ps2_data = 1'b1;
   logic       key_strobe, key_pressed, key_extended, frame_err;
   logic [7:0] key_code;

   ps2_scancode_rx #(.FILTER_LEN(8), .TIMEOUT(TO)) dut (
      .clk_sys      (clk_sys),
      .reset_n      (reset_n),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .key_strobe   (key_strobe),
      .key_pressed  (key_pressed),
      .key_extended (key_extended),
      .key_code     (key_code),
      .frame_err    (frame_err)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct packed {
      logic       err;
      logic       pressed;
      logic       ext;
      logic [7:0] code;
   } ev_t;

   ev_t         exp_q[$];
   ev_t         mon_e;
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   bit          mon_en   = 1'b0;
   logic [9:0]  hold     = '0;   // {pressed, ext, code} of last expected strobe

   // Reference model state
   bit         m_ext = 0, m_rel = 0;
   int         m_skip = 0;
   bit         m_rec_v = 0, m_rec_ext = 0;
   logic [7:0] m_rec_code = '0;

   function automatic void push_err();
      ev_t e;
      e = '{err: 1'b1, pressed: 1'b0, ext: 1'b0, code: 8'h00};
      exp_q.push_back(e);
   endfunction

   function automatic void model_frame(input logic [7:0] b, input bit ok);
      ev_t e;
      bit  suppress;
      if (!ok) begin
         push_err();
         m_ext   = 0;
         m_rel   = 0;
         m_rec_v = 0;
         return;
      end
      if (m_skip > 0) begin
         m_skip--;
         return;
      end
      case (b)
         8'hE0: begin m_ext = 1; return; end
         8'hF0: begin m_rel = 1; return; end
         8'hE1: begin m_skip = 7; return; end
         default: ;
      endcase
      if (!m_ext && !m_rel && (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF}))
         return;
      suppress = 0;
`ifdef KBD_TYPEMATIC_FILTER_EN
      if (!m_rel) begin
         suppress   = m_rec_v && m_rec_ext == m_ext && m_rec_code == b;
         m_rec_v    = 1;
         m_rec_ext  = m_ext;
         m_rec_code = b;
      end else if (m_rec_v && m_rec_ext == m_ext && m_rec_code == b) begin
         m_rec_v = 0;
      end
`endif
      if (!suppress) begin
         e = '{err: 1'b0, pressed: !m_rel, ext: m_ext, code: b};
         exp_q.push_back(e);
      end
      m_ext = 0;
      m_rel = 0;
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk_sys);
   endtask

   task automatic send_bit(input logic b, input int half);
      ps2_data = b;
      wait_cyc(half);
      ps2_clk = 1'b0;
      wait_cyc(half);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int half);
      model_frame(b, !(bad_par || bad_stop));
      send_bit(1'b0, half);
      for (int i = 0; i < 8; i++) send_bit(b[i], half);
      send_bit((~^b) ^ bad_par, half);
      send_bit(!bad_stop, half);
      ps2_data = 1'b1;
      wait_cyc(2 * half);
   endtask

   task automatic good(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b0, 20);
   endtask

   // Monitor / scoreboard
   always @(negedge clk_sys) begin
      if (mon_en) begin
         n_checks++;
         if (key_strobe || frame_err) begin
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_event: got strobe=%0b err=%0b code=%h, required no event",
                        key_strobe, frame_err, key_code);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_e.err) begin
                  if (!(frame_err && !key_strobe)) begin
                     n_fail++;
                     $display("FAIL frame_err_event: got strobe=%0b err=%0b code=%h, required strobe=0 err=1",
                              key_strobe, frame_err, key_code);
                  end
               end else begin
                  if (!key_strobe || frame_err || key_pressed !== mon_e.pressed ||
                      key_extended !== mon_e.ext || key_code !== mon_e.code) begin
                     n_fail++;
                     $display("FAIL key_event: got strobe=%0b err=%0b pressed=%0b ext=%0b code=%h, required strobe=1 err=0 pressed=%0b ext=%0b code=%h",
                              key_strobe, frame_err, key_pressed, key_extended, key_code,
                              mon_e.pressed, mon_e.ext, mon_e.code);
                  end
                  hold = {mon_e.pressed, mon_e.ext, mon_e.code};
               end
            end
         end else if ({key_pressed, key_extended, key_code} !== hold) begin
            n_fail++;
            $display("FAIL output_hold: got pressed=%0b ext=%0b code=%h, required pressed=%0b ext=%0b code=%h",
                     key_pressed, key_extended, key_code, hold[9], hold[8], hold[7:0]);
         end
      end
   end

   initial begin
      int unsigned r;
      logic [7:0]  b;
      logic [7:0]  resp [7];
      resp = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF};

      // Reset state
      wait_cyc(5);
      @(negedge clk_sys);
      n_checks++;
      if ({key_strobe, key_pressed, key_extended, key_code, frame_err} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got strobe=%0b pressed=%0b ext=%0b code=%h err=%0b, required all 0",
                  key_strobe, key_pressed, key_extended, key_code, frame_err);
      end
      reset_n = 1'b1;
      wait_cyc(5);
      mon_en = 1'b1;

      // Make, break, extended break, plain make
      good(8'h1C);
      good(8'hF0); good(8'h1C);
      good(8'hE0); good(8'hF0); good(8'h75);
      good(8'h75);

      // Parity error, recovery, prefix cleared by error
      send_frame(8'h1C, 1'b1, 1'b0, 20);
      good(8'h1B);
      good(8'hE0);
      send_frame(8'h33, 1'b1, 1'b0, 20);
      good(8'h74);

      // Stop-bit error
      good(8'hF0);
      send_frame(8'h12, 1'b0, 1'b1, 20);
      good(8'h12);

      // Timeout after 4 data bits, then recovery
      push_err();
`ifdef KBD_TYPEMATIC_FILTER_EN
      m_rec_v = 0;
`endif
      send_bit(1'b0, 20);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 20);
      ps2_data = 1'b1;
      wait_cyc(TO + 10 + 40);
      good(8'h29);

      // 3-cycle clock glitch with data low must not start a frame
      ps2_data = 1'b0;
      ps2_clk  = 1'b0;
      wait_cyc(3);
      ps2_clk  = 1'b1;
      wait_cyc(40);
      ps2_data = 1'b1;
      wait_cyc(40);
      good(8'h5A);

      // Device responses with no prefix are discarded
      good(8'hFA); good(8'hAA);

      // Pause sequence
      good(8'hE1); good(8'h14); good(8'h77); good(8'hE1);
      good(8'hF0); good(8'h14); good(8'hF0); good(8'h77);
      good(8'h5A);

      // Typematic repeats
      good(8'h1C); good(8'h1C); good(8'h1C); good(8'hF0); good(8'h1C);

      // Randomized frames
      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(0, 99);
         if (r < 15)      b = 8'hE0;
         else if (r < 30) b = 8'hF0;
         else if (r < 33) b = 8'hE1;
         else if (r < 43) b = resp[$urandom_range(0, 6)];
         else             b = 8'($urandom_range(0, 255));
         r = $urandom_range(0, 99);
         send_frame(b, r < 8, (r >= 8 && r < 12), int'($urandom_range(14, 30)));
      end

      wait_cyc(200);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL missing_events: got %0d events still pending, required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
